// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Sits on the bridge's device side with the same word-addressed slave interface
// as the timers. Only Addr[3:2] is decoded:
//   0 CTRL   : bit0 EN, bit1 IE, bit2 PEN (parity build only)
//   1 DIV    : baud divisor, bit period = DIV+1 clocks (latched at frame start)
//   2 TXDATA : write pushes Din[7:0], reads 0
//   3 STATUS : bit0 EMPTY, bit1 FULL, bit2 BUSY, bit3 OVF, bits[8:4] COUNT;
//              any write here clears OVF
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   Addr  - word address [31:2] from the bridge
//   WE    - write strobe, one cycle per store
//   Din   - write data
//   Dout  - read data, combinational from Addr[3:2]
//   IRQ   - registered level interrupt: IE & EMPTY & ~BUSY
//   tx    - serial line, idle high
//
// Build option: define UART_TX_PARITY_EN to add CTRL.PEN and an even-parity bit
// between the last data bit and the stop bit.
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        tx
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d, ie_q, ie_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic we_ctrl, we_div, push, we_status;
  logic empty, full, busy, push_ok, pop, baud_done, pen;
  logic [4:0] count5;
  logic unused_in;

`ifdef UART_TX_PARITY_EN
  logic pen_q, pen_d;
  assign pen = pen_q;
`else
  assign pen = 1'b0;
`endif

  // Base decode is done in the bridge; the remaining address bits are ignored.
  assign unused_in = ^{Addr[31:4], Din};

  assign we_ctrl   = WE && (Addr[3:2] == 2'd0);
  assign we_div    = WE && (Addr[3:2] == 2'd1);
  assign push      = WE && (Addr[3:2] == 2'd2);
  assign we_status = WE && (Addr[3:2] == 2'd3);

  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign busy      = (state_q != StIdle);
  assign push_ok   = push && !full;
  assign baud_done = (baud_cnt_q == div_sh_q);
  assign count5    = 5'(count_q);

  // Control registers, FIFO bookkeeping and interrupt.
  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    div_d    = div_q;
    ovf_d    = ovf_q;
`ifdef UART_TX_PARITY_EN
    pen_d    = pen_q;
`endif
    if (we_ctrl) begin
      en_d = Din[0];
      ie_d = Din[1];
`ifdef UART_TX_PARITY_EN
      pen_d = Din[2];
`endif
    end
    if (we_div) div_d = Din[DIV_W-1:0];
    if (we_status)         ovf_d = 1'b0;
    else if (push && full) ovf_d = 1'b1;

    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop);

    // Rises a cycle after the condition holds, but drops on the very edge that
    // pushes data or clears IE.
    irq_d = ie_q && ie_d && empty && !busy && !push;
  end

  // Transmit FSM. Pop only looks at the registered count, so a byte pushed
  // into an empty FIFO is never popped on the same edge.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    div_sh_d   = div_sh_q;
    pop        = 1'b0;
    if (state_q == StIdle) begin
      if (en_q && !empty) begin
        pop        = 1'b1;
        data_d     = mem_q[rd_ptr_q];
        div_sh_d   = div_q;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        state_d    = StStart;
      end
    end else if (!baud_done) begin
      baud_cnt_d = baud_cnt_q + DIV_W'(1);
    end else begin
      baud_cnt_d = '0;
      case (state_q)
        StStart: state_d = StData;
        StData: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = pen_q ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: state_d = StStop;
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Line level is decoded from state so reset drives tx high immediately.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = data_q[bit_cnt_q];
`ifdef UART_TX_PARITY_EN
      StParity: tx = ^data_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd0: Dout[2:0] = {pen, ie_q, en_q};
      2'd1: Dout[DIV_W-1:0] = div_q;
      2'd2: Dout = '0;
      2'd3: Dout[8:0] = {count5, ovf_q, busy, full, empty};
    endcase
  end

  assign IRQ = irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      div_sh_q   <= '0;
      div_q      <= '0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef UART_TX_PARITY_EN
      pen_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      div_sh_q   <= div_sh_d;
      div_q      <= div_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
`ifdef UART_TX_PARITY_EN
      pen_q      <= pen_d;
`endif
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= Din[7:0];
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: a frame-level model (byte queue plus a
// per-cycle list of line levels built when a frame starts) is compared against
// tx, IRQ and Dout on every falling edge; directed tests add literal checks.
module tb_uart_tx_periph;

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned DivW      = 16;
  localparam int          HistLen   = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic tx_hist  [HistLen];
  logic irq_hist [HistLen];

  uart_tx_periph #(
    .FIFO_DEPTH(FifoDepth),
    .DIV_W     (DivW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  byte unsigned    m_fifo[$];
  bit              m_wave[$];   // line level for each remaining cycle of the frame
  bit              m_en = 0, m_ie = 0, m_pen = 0, m_ovf = 0, m_irq = 0;
  logic [DivW-1:0] m_div = '0;
  int              m_pre_n;
  bit              m_pre_busy, m_push, m_old_ie;

  task automatic build_frame(input byte unsigned b);
    int per;
    per = int'(m_div) + 1;
    m_wave.delete();
    for (int k = 0; k < per; k++) m_wave.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < per; k++) m_wave.push_back(b[i]);
    if (m_pen)
      for (int k = 0; k < per; k++) m_wave.push_back(^b);
    for (int k = 0; k < per; k++) m_wave.push_back(1'b1);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_wave.delete();
      m_en = 0; m_ie = 0; m_pen = 0; m_ovf = 0; m_irq = 0; m_div = '0;
    end else begin
      m_pre_n    = m_fifo.size();
      m_pre_busy = (m_wave.size() != 0);
      m_push     = WE && (Addr[3:2] == 2'd2);
      m_old_ie   = m_ie;
      if (m_pre_busy) void'(m_wave.pop_front());
      else if (m_en && m_pre_n > 0) build_frame(m_fifo.pop_front());
      if (WE) begin
        case (Addr[3:2])
          2'd0: begin
            m_en = Din[0];
            m_ie = Din[1];
`ifdef UART_TX_PARITY_EN
            m_pen = Din[2];
`endif
          end
          2'd1: m_div = Din[DivW-1:0];
          2'd2: if (m_pre_n == FifoDepth) m_ovf = 1; else m_fifo.push_back(Din[7:0]);
          default: m_ovf = 0;
        endcase
      end
      m_irq = m_old_ie && m_ie && (m_pre_n == 0) && !m_pre_busy && !m_push;
    end
  end

  function automatic logic m_tx();
    return (m_wave.size() != 0) ? m_wave[0] : 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[2:0] = {m_pen, m_ie, m_en};
      2'd1: r[DivW-1:0] = m_div;
      2'd2: r = '0;
      default: begin
        r[0]   = (m_fifo.size() == 0);
        r[1]   = (m_fifo.size() == FifoDepth);
        r[2]   = (m_wave.size() != 0);
        r[3]   = m_ovf;
        r[8:4] = 5'(m_fifo.size());
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Per-cycle compare against the model, plus history for the literal checks.
  always @(negedge clk) begin
    if (cyc < HistLen) begin
      tx_hist[cyc]  = tx;
      irq_hist[cyc] = IRQ;
    end
    check("cyc_tx", 32'(tx), 32'(m_tx()));
    check("cyc_irq", 32'(IRQ), 32'(m_irq));
    check("cyc_dout", Dout, m_read(Addr[3:2]));
  end

  function automatic logic h_tx(input int i);
    if (i >= 0 && i < HistLen) return tx_hist[i];
    return 1'bx;
  endfunction

  function automatic logic h_irq(input int i);
    if (i >= 0 && i < HistLen) return irq_hist[i];
    return 1'bx;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] off);
    Addr = {28'($urandom), off};
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    set_addr(off);
    Din = d;
    WE  = 1'b1;
    step();
    WE  = 1'b0;
    Din = '0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] off, input logic [31:0] exp);
    set_addr(off);
    #1;
    check(name, Dout, exp);
  endtask

  task automatic do_reset();
    WE    = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Samples STATUS.BUSY for n cycles; returns busy length and first busy cycle.
  task automatic measure_busy(input int n, output int len, output int t0);
    len = 0;
    t0  = -1;
    set_addr(2'd3);
    for (int i = 0; i < n; i++) begin
      #1;
      if (Dout[2]) begin
        len++;
        if (t0 < 0) t0 = cyc;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int len, t0, ones;
    logic [9:0]  pat;
    logic [21:0] exp_tx;

    reset = 1'b0;
    WE    = 1'b0;
    Din   = '0;
    Addr  = '0;
    do_reset();

    // Reset state.
    rd_check("rst_ctrl", 2'd0, 32'h0);
    rd_check("rst_div", 2'd1, 32'h0);
    step();
    rd_check("rst_txdata", 2'd2, 32'h0);
    rd_check("rst_status", 2'd3, 32'h1);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd0);

    // 0xA5 at DIV=3: 4-clock bits, 40 busy cycles.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    wr(2'd2, 32'hA5);
    measure_busy(45, len, t0);
    check("a5_busy_len", 32'(len), 32'd40);
    pat = 10'b1101001010;
    for (int b = 0; b < 10; b++)
      check($sformatf("a5_bit%0d", b), 32'(h_tx(t0 + 4 * b + 2)), 32'(pat[b]));
    rd_check("a5_status_end", 2'd3, 32'h1);

    // Overflow: 5 pushes into a 4-deep FIFO with EN=0.
    do_reset();
    wr(2'd0, 32'h0);
    for (int i = 0; i < 5; i++) wr(2'd2, 32'(i + 16));
    rd_check("ovf_status", 2'd3, 32'h4A);
    step();
    wr(2'd3, 32'h0);
    rd_check("ovf_cleared", 2'd3, 32'h42);

    // Back-to-back frames at DIV=0 with IE; IRQ timing.
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h3);
    check("irq_not_yet", 32'(IRQ), 32'd0);
    step();
    check("irq_idle_ie", 32'(IRQ), 32'd1);
    wr(2'd2, 32'h01);
    check("irq_fall_push", 32'(IRQ), 32'd0);
    wr(2'd2, 32'h02);
    t0 = cyc;
    repeat (23) step();
    exp_tx = 22'h302602;
    for (int j = 0; j < 22; j++)
      check($sformatf("b2b_tx%0d", j), 32'(h_tx(t0 + j)), 32'(exp_tx[j]));
    check("irq_after_stop_low", 32'(h_irq(t0 + 21)), 32'd0);
    check("irq_after_stop_high", 32'(h_irq(t0 + 22)), 32'd1);
    wr(2'd2, 32'h03);
    check("irq_fall_push2", 32'(IRQ), 32'd0);

    // Mid-frame DIV change and EN clear.
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h55);
    wr(2'd2, 32'h33);
    t0 = cyc;
    repeat (6) step();
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h0);
    repeat (62) step();
    pat = 10'b1010101010;
    for (int b = 0; b < 10; b++)
      check($sformatf("mid_bit%0d", b), 32'(h_tx(t0 + 4 * b + 2)), 32'(pat[b]));
    ones = 0;
    for (int j = 40; j < 70; j++) if (h_tx(t0 + j) === 1'b1) ones++;
    check("mid_held_idle", 32'(ones), 32'd30);
    rd_check("mid_status", 2'd3, 32'h10);
    rd_check("mid_div", 2'd1, 32'd7);
    step();

    // Reset asserted mid-frame.
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    wr(2'd2, 32'h00);
    wr(2'd2, 32'h00);
    repeat (6) step();
    check("pre_reset_tx", 32'(tx), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_irq", 32'(IRQ), 32'd0);
    step();
    reset = 1'b1;
    step();
    rd_check("post_reset_status", 2'd3, 32'h1);

    // Parity option: PEN=1, 0x07 at DIV=0.
    step();
    do_reset();
    wr(2'd0, 32'h5);
    wr(2'd2, 32'h07);
    measure_busy(16, len, t0);
    check("par_first_bit", 32'(h_tx(t0 + 1)), 32'd1);
    check("par_bit7", 32'(h_tx(t0 + 8)), 32'd0);
    check("par_slot9", 32'(h_tx(t0 + 9)), 32'd1);
`ifdef UART_TX_PARITY_EN
    check("par_len", 32'(len), 32'd11);
    check("par_stop", 32'(h_tx(t0 + 10)), 32'd1);
    rd_check("par_ctrl", 2'd0, 32'h5);
`else
    check("par_len", 32'(len), 32'd10);
    rd_check("par_ctrl", 2'd0, 32'h1);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
